// File: rtl/demux_pkg.sv
// Shared types and sizing for the 1-to-8 registered demultiplexer.
package demux_pkg;

   localparam int unsigned N_LANES = 8;
   localparam int unsigned SEL_W   = $clog2(N_LANES);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      HOLD    = 2'd1
   } state_t;

   localparam logic MODE_ADDR = 1'b0;
   localparam logic MODE_SEQ  = 1'b1;

endpackage

// File: rtl/demux_if.sv
// Bundle of the demux_8 signals, with views for the design and the bench.
interface demux_if
   import demux_pkg::*;
(
   input logic clk
);

   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic               in_bit;
   logic [SEL_W-1:0]   sel;
   logic               mode;
   logic               clear;
   logic [N_LANES-1:0] out;
   logic               out_valid;
   logic               out_ready;
   logic [N_LANES-1:0] lane_mask;

   modport rtl (
      input  clk, rst, in_valid, in_bit, sel, mode, clear, out_ready,
      output in_ready, out, out_valid, lane_mask
   );

   modport tb (
      input  clk, in_ready, out, out_valid, lane_mask,
      output rst, in_valid, in_bit, sel, mode, clear, out_ready
   );

endinterface

// File: rtl/demux_lane_ctr.sv
// Wrapping lane counter used to pick the destination lane in sequential mode.
module demux_lane_ctr
   import demux_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [SEL_W-1:0] cnt
);

   // Power-of-two lane count, so natural overflow gives the 7 -> 0 wrap.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + SEL_W'(1);
      end
   end

endmodule

// File: rtl/demux_8.sv
// 1-to-8 registered demultiplexer / deserializer with a valid/ready word output.
module demux_8
   import demux_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_bit,
   input  logic [SEL_W-1:0]   sel,
   input  logic               mode,
   input  logic               clear,
   output logic [N_LANES-1:0] out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N_LANES-1:0] lane_mask
);

   state_t             state;
   state_t             state_nx;
   logic [N_LANES-1:0] out_nx;
   logic [N_LANES-1:0] mask_nx;
   logic               out_valid_nx;
   logic               cnt_inc;
   logic               cnt_clr;
   logic [SEL_W-1:0]   cnt;
   logic [SEL_W-1:0]   dest;

   demux_lane_ctr u_lane_ctr (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .cnt (cnt)
   );

   assign in_ready = (state == COLLECT);

   // Next-state and next-output decode; clear outranks every handshake.
   always_comb begin
      state_nx     = state;
      out_nx       = out;
      mask_nx      = lane_mask;
      out_valid_nx = out_valid;
      cnt_inc      = 1'b0;
      cnt_clr      = 1'b0;
      dest         = (mode == MODE_SEQ) ? cnt : sel;

      if (clear) begin
         state_nx     = COLLECT;
         mask_nx      = '0;
         out_valid_nx = 1'b0;
         cnt_clr      = 1'b1;
      end else begin
         case (state)
            COLLECT: begin
               if (in_valid) begin
                  out_nx[dest]  = in_bit;
                  mask_nx[dest] = 1'b1;
                  cnt_inc       = (mode == MODE_SEQ);
                  if (&mask_nx) begin
                     state_nx     = HOLD;
                     out_valid_nx = 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_nx     = COLLECT;
                  mask_nx      = '0;
                  out_valid_nx = 1'b0;
                  cnt_clr      = 1'b1;
               end
            end
            default: begin
               state_nx     = COLLECT;
               mask_nx      = '0;
               out_valid_nx = 1'b0;
               cnt_clr      = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= COLLECT;
         out       <= '0;
         lane_mask <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         out       <= out_nx;
         lane_mask <= mask_nx;
         out_valid <= out_valid_nx;
      end
   end

endmodule

// File: tb/tb_demux_8.sv
// Randomized and directed self-checking bench for demux_8 against a lane-array model.
module tb_demux_8;

   logic clk;
   int   n_checks;
   int   n_errors;

   // Reference model: the word being built, which lanes are filled, the
   // sequential lane pointer, and whether a finished word is being held.
   logic [7:0] m_out;
   logic [7:0] m_mask;
   int         m_cnt;
   bit         m_hold;

   demux_if bus (.clk(clk));

   demux_8 dut (
      .clk       (clk),
      .rst       (bus.rst),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_bit    (bus.in_bit),
      .sel       (bus.sel),
      .mode      (bus.mode),
      .clear     (bus.clear),
      .out       (bus.out),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .lane_mask (bus.lane_mask)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, advance the model at the edge, compare after it.
   task automatic cycle(input logic r, input logic iv, input logic b, input logic [2:0] s,
                        input logic md, input logic c, input logic ordy);
      int d;
      @(negedge clk);
      bus.rst       = r;
      bus.in_valid  = iv;
      bus.in_bit    = b;
      bus.sel       = s;
      bus.mode      = md;
      bus.clear     = c;
      bus.out_ready = ordy;
      @(posedge clk);
      if (r) begin
         m_out = '0; m_mask = '0; m_cnt = 0; m_hold = 0;
      end else if (c) begin
         m_mask = '0; m_cnt = 0; m_hold = 0;
      end else if (!m_hold) begin
         if (iv) begin
            d = md ? m_cnt : int'(s);
            m_out[d]  = b;
            m_mask[d] = 1'b1;
            if (md) m_cnt = (m_cnt + 1) % 8;
            if ($countones(m_mask) == 8) m_hold = 1;
         end
      end else if (ordy) begin
         m_mask = '0; m_cnt = 0; m_hold = 0;
      end
      #1;
      check("out",       32'(bus.out),       32'(m_out));
      check("lane_mask", 32'(bus.lane_mask), 32'(m_mask));
      check("out_valid", 32'(bus.out_valid), 32'(m_hold));
      check("in_ready",  32'(bus.in_ready),  32'(!m_hold));
   endtask

   task automatic seq_word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) cycle(0, 1, w[i], 3'($urandom), 1, 0, 0);
   endtask

   task automatic release_word();
      cycle(0, 0, 0, 0, 0, 0, 1);
      check("released_valid", 32'(bus.out_valid), 32'd0);
      check("released_mask",  32'(bus.lane_mask), 32'd0);
      check("released_ready", 32'(bus.in_ready),  32'd1);
   endtask

   initial begin
      logic [2:0] sels [8];
      logic [7:0] w;
      n_checks = 0;
      n_errors = 0;
      m_out = '0; m_mask = '0; m_cnt = 0; m_hold = 0;
      bus.rst = 1; bus.in_valid = 0; bus.in_bit = 0; bus.sel = 0;
      bus.mode = 0; bus.clear = 0; bus.out_ready = 0;

      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 1, 3, 1, 0, 1);
      check("reset_out", 32'(bus.out), 32'd0);
      check("reset_ready", 32'(bus.in_ready), 32'd1);

      // Sequential load: lane0 takes the first bit.
      seq_word(8'b0100_1101);
      check("seq_out",   32'(bus.out),       32'h4D);
      check("seq_valid", 32'(bus.out_valid), 32'd1);
      check("seq_mask",  32'(bus.lane_mask), 32'hFF);
      check("seq_ready", 32'(bus.in_ready),  32'd0);
      release_word();

      // Addressed out-of-order load, lane3 gets 0.
      sels = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
      foreach (sels[i]) cycle(0, 1, (sels[i] != 3'd3), sels[i], 0, 0, 0);
      check("addr_out",   32'(bus.out),       32'hF7);
      check("addr_valid", 32'(bus.out_valid), 32'd1);
      release_word();

      // Overwrite lane2, then fill the rest.
      cycle(0, 1, 1, 2, 0, 0, 0);
      cycle(0, 1, 0, 2, 0, 0, 0);
      check("ovw_mask",  32'(bus.lane_mask), 32'h04);
      check("ovw_valid", 32'(bus.out_valid), 32'd0);
      for (int l = 0; l < 8; l++) if (l != 2) cycle(0, 1, 1, 3'(l), 0, 0, 0);
      check("ovw_out", 32'(bus.out), 32'hFB);

      // Backpressure: held word ignores input samples.
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 1'($urandom), 3'($urandom), 1'($urandom), 0, 0);
         check("bp_out",   32'(bus.out),      32'hFB);
         check("bp_ready", 32'(bus.in_ready), 32'd0);
      end
      release_word();

      // clear mid-frame drops the concurrent sample and restarts at lane0.
      for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 1, 0, 0);
      cycle(0, 1, 0, 0, 1, 1, 0);
      check("clr_mask", 32'(bus.lane_mask), 32'd0);
      w = 8'($urandom);
      seq_word(w);
      check("clr_word", 32'(bus.out), 32'(w));
      check("clr_valid", 32'(bus.out_valid), 32'd1);

      // Reset while holding.
      cycle(1, 0, 0, 0, 0, 0, 0);
      check("rst_hold_out",   32'(bus.out),       32'd0);
      check("rst_hold_valid", 32'(bus.out_valid), 32'd0);
      check("rst_hold_mask",  32'(bus.lane_mask), 32'd0);
      seq_word(8'h81);
      check("wrap_out", 32'(bus.out), 32'h81);
      release_word();

      // Randomized traffic with occasional clear and reset.
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 199) == 0), 1'($urandom), 1'($urandom), 3'($urandom),
               1'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/demux_8.md
Name: demux_8

Overview:
- 1-to-8 registered demultiplexer and deserializer. It is the receive-side counterpart of the 8:1 bit mux.
- Single-bit input samples are steered into one of 8 output lanes, either by an external select (addressed mode) or by an internal lane counter (sequential mode).
- Once every lane has been written, the assembled 8-bit word is presented with a valid/ready handshake.
- Sits between a serial bit source (or mux-based serializer) and 8-bit parallel consumers.

Parameters:
- N_LANES, 8, number of output lanes. The design is verified at 8 only.
- SEL_W, 3, select/counter width. Equals $clog2(N_LANES).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bit/sel/mode qualify an input sample this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- in_bit  input  1  data bit to steer.
- sel  input  SEL_W  destination lane; used in addressed mode only.
- mode  input  1  0 = addressed (sel), 1 = sequential (internal counter); sampled per accepted sample.
- clear  input  1  synchronous frame abort.
- out  output  N_LANES  assembled word.
- out_valid  output  1  out holds a complete word.
- out_ready  input  1  consumer accepts the word.
- lane_mask  output  N_LANES  lanes written in the current frame.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst. These are already decided.
- Reset values (rst high at a clk edge): out=0, lane_mask=0, out_valid=0, lane counter cnt=0, state=COLLECT.
- Priority: rst > clear > handshakes.
- State COLLECT: in_ready=1, out_valid=0.
- Accept: in_valid & in_ready at an edge.
  - Destination lane d = sel when mode=0; d = cnt when mode=1.
  - out[d] <= in_bit; lane_mask[d] <= 1.
  - In mode 1 only: cnt <= cnt+1, wrapping 7 -> 0. cnt does not move on mode-0 accepts.
  - Other lanes of out are unchanged.
- Rewriting a lane already in lane_mask (addressed mode) overwrites its bit; the mask is unchanged; no error.
- Completion: if the post-write mask is all ones, the state becomes HOLD at the same edge.
  - out_valid is high the cycle after the final accept (1-cycle latency).
  - The final bit is already reflected in out.
- State HOLD: in_ready=0, out_valid=1. out and lane_mask are stable; in_valid is ignored.
- HOLD exit: out_valid & out_ready at an edge.
  - out_valid <= 0, lane_mask <= 0, cnt <= 0, state <= COLLECT.
  - out retains the delivered word until lanes are rewritten.
  - A new sample can be accepted on the following cycle, so there is no same-cycle accept/release bypass.
- out_ready in COLLECT: no effect.
- clear (any state): lane_mask <= 0, cnt <= 0, out_valid <= 0, state <= COLLECT. out retains its value.
  - A same-cycle in_valid is dropped.
  - A same-cycle out_ready has no additional effect.
- Mixed modes within a frame are legal; completion is purely mask-based.
- Reset mid-frame or mid-HOLD discards the partial or held word; all outputs return to their reset values.
- in_ready is combinational from state only (state==COLLECT). There are no other combinational input-to-output paths.
- No X propagation: sel is ignored when mode=1, and all inputs are ignored when in_valid=0.

Decomposition:
- Shared package demux_pkg:
  - N_LANES and SEL_W localparams.
  - state enum typedef {COLLECT, HOLD} (2-bit encoding).
  - mode constants MODE_ADDR=1'b0, MODE_SEQ=1'b1.
- Companion interface demux_if with modports rtl and tb, following the mux interface style; the module exposes the plain ports above.
- No sub-module is required. An optional demux_lane_ctr holds the wrapping counter; that split is natural if a serializer later reuses it.

Test Plan:
- Reset then sequential load: mode=1; bits 1,0,1,1,0,0,1,0 on 8 consecutive in_valid cycles.
  - Required response: out_valid high the cycle after the 8th accept; out=8'b0100_1101 (lane0 = first bit); lane_mask=8'hFF; in_ready=0.
- Addressed out-of-order load: mode=0; sel=7,3,0,5,1,6,2,4 with in_bit=1 except sel=3 given 0.
  - Required response: out=8'hF7 and out_valid=1 after the last accept.
- Overwrite: mode=0; write lane2=1 then lane2=0, then the remaining 7 lanes with 1.
  - Required response: out=8'hFB; the mask does not complete after only the two lane-2 writes.
- Backpressure: with a held word, keep out_ready=0 for 5 cycles while driving in_valid with different bits.
  - Required response: out unchanged, in_ready=0 throughout.
  - Then pulse out_ready=1: out_valid=0 the next cycle, lane_mask=0, in_ready=1.
- clear mid-frame: mode=1; accept 4 bits, then assert clear together with in_valid.
  - Required response: lane_mask=0, cnt=0, the sample is dropped; the next 8 accepts form a fresh word starting at lane0.
- Reset in HOLD: with out_valid=1, pulse rst.
  - Required response: next cycle out=0, out_valid=0, lane_mask=0, in_ready=1.
  - Wrap check: a mode-1 frame immediately after restarts at lane0.
